// File: rtl/core_pkg.sv
// Shared constants and types for the 16-bit core.
// Used by the fetch queue and its storage.
package core_pkg;

    localparam int PC_W   = 9;
    localparam int INST_W = 16;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Prefetch storage: synchronous write, combinational head read.
// A flush empties the queue and takes priority over both ports.
module fq_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = $bits(fq_entry_t),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr;
    logic          w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A write into a full queue is a protocol error and is dropped.
    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, 1-cycle imem,
// tagged prefetch queue toward decode, flush on redirect.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = core_pkg::PC_W,
    parameter int INST_W = core_pkg::INST_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(core_pkg::RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_valid,
    input  logic [INST_W-1:0]      imem_rdata,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [INST_W-1:0]      dec_inst,
    output logic [PC_W-1:0]        dec_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + PC_W;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_req_pc;
    logic            r_inflight;
    logic            r_kill;

    logic            w_credit;
    logic            w_req;
    logic            w_wr;
    logic            w_deq;
    logic [EW-1:0]   w_head;
    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;

    // Credit uses registered occupancy only; a same-cycle pop is ignored.
    assign w_credit = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < DEPTH_V;
    assign w_req    = rst_n && !redirect && w_credit;

    assign w_wr  = imem_valid && r_inflight && !r_kill && !redirect;
    assign w_deq = dec_valid && dec_ready;

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign dec_valid = !w_empty && !redirect;
    assign dec_inst  = w_head[EW-1:PC_W];
    assign dec_pc    = w_head[PC_W-1:0];
    assign count     = w_count;
    assign full      = w_full;
    assign empty     = w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_inflight <= w_req;
            r_kill     <= redirect && r_inflight;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_req) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
                r_req_pc   <= r_fetch_pc;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (redirect),
        .i_wr_en   (w_wr),
        .i_wr_data ({imem_rdata, r_req_pc}),
        .i_rd_en   (w_deq),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: ideal 1-cycle imem, queue-level reference model.
module tb_fetch_queue;
    import core_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 1 + PC_W + 1 + INST_W + PC_W + CW + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [INST_W-1:0] dec_inst;
    logic [PC_W-1:0]   dec_pc;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    int checks = 0;
    int errors = 0;

    fq_entry_t       mq[$];
    logic [PC_W-1:0] m_fpc;
    logic [PC_W-1:0] m_pend_pc;
    bit              m_pend;
    bit              glitch;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    function automatic logic [INST_W-1:0] mem(input logic [PC_W-1:0] a);
        return 16'h1000 + {{(INST_W - PC_W){1'b0}}, a};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {imem_req, imem_req ? imem_addr : PC_W'(0),
                dec_valid, dec_valid ? dec_inst : INST_W'(0),
                dec_valid ? dec_pc : PC_W'(0), count, full, empty};
    endfunction

    function automatic logic [VW-1:0] expv();
        int        sz = mq.size();
        bit        rq = (sz + int'(m_pend) < DEPTH) && !redirect;
        bit        dv = (sz != 0) && !redirect;
        fq_entry_t h  = (sz != 0) ? mq[0] : '0;
        return {rq, rq ? m_fpc : PC_W'(0),
                dv, dv ? h.inst : INST_W'(0), dv ? h.pc : PC_W'(0),
                CW'(sz), sz == DEPTH, sz == 0};
    endfunction

    function automatic void model_step();
        int sz = mq.size();
        bit issue;
        if (redirect) begin
            mq.delete();
            m_fpc  = redirect_pc;
            m_pend = 0;
            return;
        end
        issue = (sz + int'(m_pend)) < DEPTH;
        if (sz != 0 && dec_ready) void'(mq.pop_front());
        if (m_pend && sz < DEPTH)
            mq.push_back('{inst: mem(m_pend_pc), pc: m_pend_pc});
        m_pend = issue;
        if (issue) begin
            m_pend_pc = m_fpc;
            m_fpc     = m_fpc + 1'b1;
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_fpc  = RESET_PC;
        m_pend = 0;
    endfunction

    task automatic tick();
        logic            s_req;
        logic [PC_W-1:0] s_addr;
        s_req  = imem_req;
        s_addr = imem_addr;
        model_step();
        @(posedge clk);
        #1;
        imem_valid = s_req || (glitch && $urandom_range(0, 3) == 0);
        imem_rdata = s_req ? mem(s_addr) : INST_W'($urandom);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b0;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        glitch      = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        dec_ready   = 1'b1;
        imem_valid  = 1'b0;
        imem_rdata  = '0;
        @(negedge clk);
        checks++;
        if ({dec_valid, imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL reset_hs got=%b exp=00", {dec_valid, imem_req});
        end
        checks++;
        if ({empty, full, count} !== {1'b1, 1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=10%b", {empty, full, count}, CW'(0));
        end
        checks++;
        if ({dec_inst, dec_pc} !== '0) begin
            errors++;
            $display("FAIL reset_head got=%h/%h exp=0/0", dec_inst, dec_pc);
        end
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        dec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL stream c=%0d got=%h exp=%h", c, obs(), expv());
            end
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== PC_W'(c)) begin
                errors++;
                $display("FAIL stream_addr c=%0d got=%b/%h exp=1/%h",
                         c, imem_req, imem_addr, PC_W'(c));
            end
            if (c < 3) begin
                checks++;
                if (dec_valid !== (c == 2)) begin
                    errors++;
                    $display("FAIL stream_latency c=%0d got=%b", c, dec_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int              nreq = 0;
        logic [PC_W-1:0] got[$];
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL bp_fill c=%0d got=%h exp=%h", c, obs(), expv());
            end
            nreq += int'(imem_req);
            tick();
        end
        @(negedge clk);
        checks++;
        if ({full, count, imem_req} !== {1'b1, CW'(DEPTH), 1'b0}) begin
            errors++;
            $display("FAIL bp_full got=%b/%0d/%b exp=1/4/0", full, count, imem_req);
        end
        checks++;
        if (nreq != 4) begin
            errors++;
            $display("FAIL bp_nreq got=%0d exp=4", nreq);
        end
        tick();
        dec_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL bp_drain c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (dec_valid) got.push_back(dec_pc);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== PC_W'(i)) begin
                errors++;
                $display("FAIL bp_order i=%0d got=%h exp=%h",
                         i, (got.size() > i) ? got[i] : PC_W'(0), PC_W'(i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 14; c++) begin
            dec_ready   = (c < 4) || (c > 6);
            redirect    = (c == 6);
            redirect_pc = 9'h040;
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL redir c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (c == 6) begin
                checks++;
                if (count !== CW'(3)) begin
                    errors++;
                    $display("FAIL redir_pre got=%0d exp=3", count);
                end
            end
            if (c == 7) begin
                checks++;
                if ({count, imem_req, imem_addr} !== {CW'(0), 1'b1, 9'h040}) begin
                    errors++;
                    $display("FAIL redir_restart got=%0d/%b/%h exp=0/1/040",
                             count, imem_req, imem_addr);
                end
            end
            if (c == 9) begin
                checks++;
                if (dec_valid !== 1'b1 || dec_pc !== 9'h040) begin
                    errors++;
                    $display("FAIL redir_first got=%b/%h exp=1/040", dec_valid, dec_pc);
                end
            end
            tick();
        end
        redirect = 1'b0;
    endtask

    task automatic test_redirect_ready();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            dec_ready   = (c != 4);
            redirect    = (c == 5);
            redirect_pc = 9'h0A0;
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL redir_rdy c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (c == 5) begin
                checks++;
                if ({dec_valid, count} !== {1'b0, CW'(2)}) begin
                    errors++;
                    $display("FAIL redir_rdy_hs got=%b/%0d exp=0/2", dec_valid, count);
                end
            end
            if (c == 6) begin
                checks++;
                if ({count, empty} !== {CW'(0), 1'b1}) begin
                    errors++;
                    $display("FAIL redir_rdy_flush got=%0d/%b exp=0/1", count, empty);
                end
            end
            tick();
        end
        redirect = 1'b0;
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] got[$];
        logic [PC_W-1:0] wexp [4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
        do_reset();
        dec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            redirect    = (c == 2);
            redirect_pc = 9'h1FE;
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL wrap c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (c > 2 && dec_valid) got.push_back(dec_pc);
            tick();
        end
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got.size() <= i || got[i] !== wexp[i]) begin
                errors++;
                $display("FAIL wrap_seq i=%0d got=%h exp=%h",
                         i, (got.size() > i) ? got[i] : PC_W'(0), wexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] p1;
        logic [PC_W-1:0] p2;
        logic [PC_W-1:0] first;
        bit              seen = 0;
        p1 = PC_W'($urandom);
        p2 = p1 ^ 9'h155;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            dec_ready   = (c < 3) ? 1'($urandom) : 1'b1;
            redirect    = (c == 4) || (c == 5);
            redirect_pc = (c == 4) ? p1 : p2;
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL b2b c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (c > 5 && dec_valid && !seen) begin
                first = dec_pc;
                seen  = 1;
            end
            tick();
        end
        redirect = 1'b0;
        checks++;
        if (!seen || first !== p2) begin
            errors++;
            $display("FAIL b2b_target got=%h exp=%h", seen ? first : PC_W'(0), p2);
        end
    endtask

    task automatic test_random();
        do_reset();
        glitch = 1;
        for (int c = 0; c < 400; c++) begin
            dec_ready   = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = PC_W'($urandom);
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random c=%0d got=%h exp=%h", c, obs(), expv());
            end
            tick();
        end
        redirect = 1'b0;
        glitch   = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL arst_fill c=%0d got=%h exp=%h", c, obs(), expv());
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (count !== CW'(3)) begin
            errors++;
            $display("FAIL arst_pre got=%0d exp=3", count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dec_valid, imem_req, count} !== {2'b00, CW'(0)}) begin
            errors++;
            $display("FAIL arst_now got=%b/%b/%0d exp=0/0/0", dec_valid, imem_req, count);
        end
        do_reset();
        dec_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL arst_post c=%0d got=%h exp=%h", c, obs(), expv());
            end
            if (c == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
                    errors++;
                    $display("FAIL arst_restart got=%b/%h exp=1/%h",
                             imem_req, imem_addr, RESET_PC);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_ready();
        test_wrap();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
